bitbrick_seq_ctrl: RTL

- Sequencing controller that time-multiplexes one bitbrick to compute variable-precision multiplies (2/4/8-bit operands, each signed or unsigned).
- Slices each operand into 2-bit chunks and issues one chunk pair to the bitbrick per cycle.
- Sign-extends, shifts and accumulates the bitbrick partial products into a 16-bit result.
- Sits between the operand-fetch stage (valid/ready in) and the accumulator stage (valid/ready out). It is the single-brick, temporal counterpart of a fusion unit.

---
 rtl/bitbrick_seq_ctrl_if.sv | 29 ++
 rtl/bitbrick_seq_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bitbrick_seq_ctrl_if.sv
// Operand-request and result handshake bundle for the bitbrick sequencing controller.
// The controller takes the slave view; the operand fetch and accumulator side take the master view.
interface bitbrick_seq_ctrl_if #(
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [MAX_BITS-1:0] a;
    logic [MAX_BITS-1:0] b;
    logic [1:0]          prec_a;
    logic [1:0]          prec_b;
    logic                signed_a;
    logic                signed_b;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_W-1:0]    result;
    logic                busy;

    modport slave (
        input  in_valid, a, b, prec_a, prec_b, signed_a, signed_b, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, a, b, prec_a, prec_b, signed_a, signed_b, out_ready,
        input  in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/bitbrick_seq_ctrl.sv
// Time-multiplexes a single 2-bit bitbrick to form 2/4/8-bit signed/unsigned products,
// one slice pair per cycle, shifting and accumulating partial products into a 16-bit result.
//
//   state  | meaning
//   IDLE   | ready for a request, bitbrick inputs held at zero
//   RUN    | one slice pair per cycle, j (b-slice) inner, i (a-slice) outer
//   DONE   | result presented, waiting for out_ready
module bitbrick_seq_ctrl #(
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    bitbrick_seq_ctrl_if.slave  io,
    output logic [1:0]          o_bb_x,
    output logic                o_bb_sx,
    output logic [1:0]          o_bb_y,
    output logic                o_bb_sy,
    output logic                o_bb_shift,
    input  logic [9:0]          i_bb_prod
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MAX_BITS-1:0] r_a;
    logic [MAX_BITS-1:0] r_b;
    logic                r_sa;
    logic                r_sb;
    logic [1:0]          r_na_m1;
    logic [1:0]          r_nb_m1;
    logic [1:0]          r_i;
    logic [1:0]          r_j;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_result;

    logic [MAX_BITS-1:0] w_a_sh;
    logic [MAX_BITS-1:0] w_b_sh;
    logic [3:0]          w_shamt;
    logic [ACC_W-1:0]    w_pp;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic                w_last;
    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_busy;
    logic                w_unused_prod_hi;

    // prec 00 -> 1 slice, 01 -> 2 slices, 10/11 -> 4 slices (returned as count-1)
    function automatic logic [1:0] slices_m1(input logic [1:0] prec);
        case (prec)
            2'b00:   slices_m1 = 2'd0;
            2'b01:   slices_m1 = 2'd1;
            default: slices_m1 = 2'd3;
        endcase
    endfunction

    assign w_a_sh    = r_a >> {r_i, 1'b0};
    assign w_b_sh    = r_b >> {r_j, 1'b0};
    assign w_last    = (r_i == r_na_m1) && (r_j == r_nb_m1);
    assign w_shamt   = {({1'b0, r_i} + {1'b0, r_j}), 1'b0};
    // Only the low 6 bits of the brick product are meaningful for 2x2 slices
    assign w_pp      = {{(ACC_W-6){i_bb_prod[5]}}, i_bb_prod[5:0]} << w_shamt;
    assign w_acc_nxt = r_acc + w_pp;
    assign w_unused_prod_hi = ^i_bb_prod[9:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        o_bb_x      = 2'b00;
        o_bb_sx     = 1'b0;
        o_bb_y      = 2'b00;
        o_bb_sy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (io.in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_busy  = 1'b1;
                o_bb_x  = w_a_sh[1:0];
                o_bb_sx = r_sa && (r_i == r_na_m1);
                o_bb_y  = w_b_sh[1:0];
                o_bb_sy = r_sb && (r_j == r_nb_m1);
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (io.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_na_m1  <= 2'd0;
            r_nb_m1  <= 2'd0;
            r_i      <= 2'd0;
            r_j      <= 2'd0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        r_a     <= io.a;
                        r_b     <= io.b;
                        r_sa    <= io.signed_a;
                        r_sb    <= io.signed_b;
                        r_na_m1 <= slices_m1(io.prec_a);
                        r_nb_m1 <= slices_m1(io.prec_b);
                        r_i     <= 2'd0;
                        r_j     <= 2'd0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    if (r_j == r_nb_m1) begin
                        r_j <= 2'd0;
                        r_i <= r_i + 2'd1;
                    end else begin
                        r_j <= r_j + 2'd1;
                    end
                    if (w_last) r_result <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = w_in_ready;
    assign io.out_valid = w_out_valid;
    assign io.busy      = w_busy;
    assign io.result    = r_result;
    assign o_bb_shift   = 1'b0;
endmodule
